// File: rtl/mips_bus_arbiter_pkg.sv
// Shared types and constants for the MIPS memory-bus arbiter slice.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_DONE
    } bus_state_t;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mips_bus_arbiter_if.sv
// Avalon-style memory bus between the arbiter (master) and memory (slave).
interface mips_bus_arbiter_if #(
    parameter int unsigned ADDR_W = mips_bus_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W = mips_bus_pkg::DATA_W_DEF
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic              waitrequest;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mips_bus_arbiter_rr.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module mips_rr_arbiter
    import mips_bus_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned IDX_W  = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx
);

    // Scan from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        int unsigned idx;
        grant     = '0;
        grant_idx = last_grant;
        idx       = 0;
        for (int unsigned k = NUM_CH; k >= 1; k--) begin
            idx = 32'(last_grant) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (req[IDX_W'(idx)]) grant_idx = IDX_W'(idx);
        end
        if (|req) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Round-robin bus master multiplexing NUM_CH request channels onto one Avalon bus.
// Optional stall timeout (and the TIMEOUT_CYCLES parameter) enabled by BUS_TIMEOUT_EN.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
`ifdef BUS_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 256,
`endif
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH-1:0]          ch_we,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
    input  logic [NUM_CH*DATA_W/8-1:0] ch_be,
    output logic [NUM_CH-1:0]          ch_ack,
    output logic [NUM_CH-1:0]          ch_err,
    output logic [DATA_W-1:0]          ch_rdata,
    output logic                       busy,
    mips_bus_arbiter_if.master         bus
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
    localparam int unsigned OFF_W = clog2(BE_W);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

    bus_state_t        state_q, state_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [IDX_W-1:0]  gnt_q, gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [NUM_CH-1:0] ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [NUM_CH-1:0] rr_grant;
    logic [IDX_W-1:0]  rr_idx;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [BE_W-1:0]   sel_be;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] err_q, err_d;
`endif

    mips_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr (
        .req        (ch_req),
        .last_grant (last_q),
        .grant      (rr_grant),
        .grant_idx  (rr_idx)
    );

    assign sel_we    = ch_we[rr_idx];
    assign sel_addr  = ch_addr[rr_idx*ADDR_W +: ADDR_W];
    assign sel_wdata = ch_wdata[rr_idx*DATA_W +: DATA_W];
    assign sel_be    = ch_be[rr_idx*BE_W +: BE_W];

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        read_d  = read_q;
        write_d = write_q;
        ack_d   = '0;
        rdata_d = rdata_q;
`ifdef BUS_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = '0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (|rr_grant) begin
                    last_d  = rr_idx;
                    gnt_d   = rr_idx;
                    addr_d  = sel_addr & ALIGN_MASK;
                    wdata_d = sel_wdata;
                    be_d    = (!sel_we && sel_be == '0) ? '1 : sel_be;
                    read_d  = !sel_we;
                    write_d = sel_we && (sel_be != '0);
                    state_d = S_BUS;
`ifdef BUS_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_BUS: begin
                // A zero-byte-enable write has no strobe and leaves S_BUS without waiting.
                if (!(read_q || write_q) || !bus.waitrequest) begin
                    if (read_q) rdata_d = bus.readdata;
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    ack_d[gnt_q] = 1'b1;
                    state_d      = S_DONE;
                end
`ifdef BUS_TIMEOUT_EN
                // Abort on the stall cycle that brings the count to TIMEOUT_CYCLES.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d      = '0;
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    ack_d[gnt_q] = 1'b1;
                    err_d[gnt_q] = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            last_q  <= IDX_W'(NUM_CH - 1);
            gnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            ack_q   <= '0;
            rdata_q <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            read_q  <= read_d;
            write_q <= write_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.address    = addr_q;
    assign bus.writedata  = wdata_q;
    assign bus.byteenable = be_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign ch_ack         = ack_q;
    assign ch_rdata       = rdata_q;
    assign busy           = (state_q != S_IDLE);
`ifdef BUS_TIMEOUT_EN
    assign ch_err         = err_q;
`else
    assign ch_err         = '0;
`endif

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter with a transaction-level reference model.
`timescale 1ns/1ps
module tb_mips_bus_arbiter;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
`ifdef BUS_TIMEOUT_EN
    localparam int TO = 4;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        ch_req, ch_we, ch_ack, ch_err;
    logic [63:0]       ch_addr, ch_wdata;
    logic [7:0]        ch_be;
    logic [31:0]       ch_rdata;
    logic              busy;

    int errors = 0;
    int checks = 0;

    mips_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mips_bus_arbiter #(
`ifdef BUS_TIMEOUT_EN
        .TIMEOUT_CYCLES (TO),
`endif
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ch_req   (ch_req),
        .ch_we    (ch_we),
        .ch_addr  (ch_addr),
        .ch_wdata (ch_wdata),
        .ch_be    (ch_be),
        .ch_ack   (ch_ack),
        .ch_err   (ch_err),
        .ch_rdata (ch_rdata),
        .busy     (busy),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, tracked as a record plus stall count.
    typedef struct {
        int          ch;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    txn_t        cur;
    bit          have_txn = 0;
    bit          model_on = 0;
    bit          finish, tout;
    int          last_ch, stalls, c;
    logic        e_read, e_write, e_busy;
    logic [1:0]  e_ack, e_err;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_be;
    bit          e_rdata_chk;

    always @(posedge clk) begin
        if (reset) begin
            model_on = 1; have_txn = 0; last_ch = NUM_CH - 1;
            e_read = 0; e_write = 0; e_busy = 0; e_ack = 0; e_err = 0;
            e_addr = 0; e_wdata = 0; e_rdata = 0; e_be = 0; e_rdata_chk = 0;
        end else if (model_on) begin
            if (e_ack != 0) begin
                e_ack = 0; e_err = 0; e_busy = 0; e_rdata_chk = 0; have_txn = 0;
            end else if (!have_txn) begin
                for (int k = 1; k <= NUM_CH; k++) begin
                    c = (last_ch + k) % NUM_CH;
                    if (ch_req[c] && !have_txn) begin
                        have_txn  = 1;
                        cur.ch    = c;
                        cur.we    = ch_we[c];
                        cur.addr  = ch_addr[c*32 +: 32];
                        cur.wdata = ch_wdata[c*32 +: 32];
                        cur.be    = ch_be[c*4 +: 4];
                    end
                end
                if (have_txn) begin
                    last_ch = cur.ch; stalls = 0; e_busy = 1; e_rdata_chk = 0;
                    e_addr  = cur.addr & ~32'h3;
                    e_wdata = cur.wdata;
                    e_be    = (cur.be == 0 && !cur.we) ? 4'hF : cur.be;
                    e_read  = !cur.we;
                    e_write = cur.we && cur.be != 0;
                end
            end else begin
                finish = 0; tout = 0;
                if (!(e_read || e_write) || !bus.waitrequest) finish = 1;
                else begin
                    stalls++;
`ifdef BUS_TIMEOUT_EN
                    if (stalls == TO) begin finish = 1; tout = 1; end
`endif
                end
                if (finish) begin
                    e_ack[cur.ch] = 1'b1;
                    e_err[cur.ch] = tout;
                    if (e_read) begin
                        e_rdata = tout ? 32'h0 : bus.readdata;
                        e_rdata_chk = 1;
                    end
                    e_read = 0; e_write = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("cmp_read", bus.read, e_read);
            chk("cmp_write", bus.write, e_write);
            chk("cmp_busy", busy, e_busy);
            chk("cmp_ch_ack", ch_ack, e_ack);
            chk("cmp_ch_err", ch_err, e_err);
            if (e_read || e_write) begin
                chk("cmp_address", bus.address, e_addr);
                chk("cmp_byteenable", bus.byteenable, e_be);
            end
            if (e_write) chk("cmp_writedata", bus.writedata, e_wdata);
            if (e_ack != 0 && e_rdata_chk) chk("cmp_ch_rdata", ch_rdata, e_rdata);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_ch(input int ch, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        ch_we[ch]           = we;
        ch_addr[ch*32 +: 32]  = addr;
        ch_wdata[ch*32 +: 32] = wdata;
        ch_be[ch*4 +: 4]    = be;
        ch_req[ch]          = 1'b1;
    endtask

    int n, cyc;
    logic [3:0] order;

    initial begin
        ch_req = 0; ch_we = 0; ch_addr = 0; ch_wdata = 0; ch_be = 0;
        bus.waitrequest = 0; bus.readdata = 0; reset = 1;
        repeat (2) step();
        reset = 0;
        chk("rst_read", bus.read, 0);
        chk("rst_write", bus.write, 0);
        chk("rst_address", bus.address, 0);
        chk("rst_byteenable", bus.byteenable, 0);
        chk("rst_writedata", bus.writedata, 0);
        chk("rst_ch_rdata", ch_rdata, 0);
        chk("rst_busy", busy, 0);

        // Read with no wait states
        set_ch(0, 0, 32'h1000_0004, 32'h0, 4'hF);
        bus.readdata = 32'hDEAD_BEEF;
        step();
        chk("t1_read", bus.read, 1);
        chk("t1_address", bus.address, 32'h1000_0004);
        step();
        chk("t1_ack", ch_ack, 2'b01);
        chk("t1_rdata", ch_rdata, 32'hDEAD_BEEF);
        ch_req = 0;
        step();

        // Three wait states; channel inputs change mid-flight
        set_ch(0, 0, 32'h1000_0004, 32'h0, 4'hF);
        bus.waitrequest = 1;
        bus.readdata = 32'h0BAD_F00D;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("t2_read", bus.read, 1);
            chk("t2_address", bus.address, 32'h1000_0004);
            chk("t2_byteenable", bus.byteenable, 4'hF);
            chk("t2_no_ack", ch_ack, 2'b00);
            ch_addr[31:0] = 32'h5555_5550 + 32'(i);
            if (i == 4) bus.waitrequest = 0;
        end
        step();
        chk("t2_ack", ch_ack, 2'b01);
        chk("t2_rdata", ch_rdata, 32'h0BAD_F00D);
        ch_req = 0;
        step();

        // Read with zero byte enables
        set_ch(0, 0, 32'h1000_0010, 32'h0, 4'h0);
        bus.readdata = 32'h7777_0001;
        step();
        chk("t3_byteenable", bus.byteenable, 4'hF);
        step();
        chk("t3_ack", ch_ack, 2'b01);
        ch_req = 0;
        step();

        // Unaligned write on ch1
        set_ch(1, 1, 32'h2000_0006, 32'h0000_1234, 4'b0011);
        step();
        chk("t4_address", bus.address, 32'h2000_0004);
        chk("t4_byteenable", bus.byteenable, 4'b0011);
        chk("t4_write", bus.write, 1);
        chk("t4_writedata", bus.writedata, 32'h0000_1234);
        step();
        chk("t4_ack", ch_ack, 2'b10);
        ch_req = 0;
        step();

        // Zero byte-enable write: no strobe, normal ack timing
        set_ch(1, 1, 32'h2000_0008, 32'h0000_FFFF, 4'b0000);
        step();
        chk("t5_write", bus.write, 0);
        step();
        chk("t5_ack", ch_ack, 2'b10);
        ch_req = 0;
        step();

        // Fairness with both channels requesting continuously
        set_ch(0, 0, 32'h3000_0000, 32'h0, 4'hF);
        set_ch(1, 0, 32'h3000_0100, 32'h0, 4'hF);
        bus.readdata = 32'hCAFE_0000;
        n = 0; cyc = 0; order = 0;
        while (n < 4 && cyc < 40) begin
            step();
            cyc++;
            bus.readdata = bus.readdata + 32'd1;
            if (ch_ack != 0) begin
                chk("fair_onehot", 64'($countones(ch_ack)), 1);
                order[n] = ch_ack[1];
                n++;
            end
        end
        ch_req = 0;
        chk("fair_ack_count", 64'(n), 4);
        chk("fair_order", order, 4'b1010);
        step();

        // Reset in the middle of a stalled transfer
        set_ch(0, 0, 32'h4000_0000, 32'h0, 4'hF);
        bus.waitrequest = 1;
        step();
        chk("t6_pre_read", bus.read, 1);
        reset = 1;
        step();
        chk("t6_read", bus.read, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ack", ch_ack, 2'b00);
        reset = 0; ch_req = 0; bus.waitrequest = 0;
        step();
        set_ch(0, 0, 32'h4000_0010, 32'h0, 4'hF);
        set_ch(1, 0, 32'h4000_0020, 32'h0, 4'hF);
        step();
        step();
        chk("t6_grant_ch0", ch_ack, 2'b01);
        ch_req = 0;
        step();

`ifdef BUS_TIMEOUT_EN
        // Stuck waitrequest aborts after TO stall cycles
        set_ch(0, 0, 32'h5000_0000, 32'h0, 4'hF);
        bus.waitrequest = 1;
        bus.readdata = 32'h1234_5678;
        for (int i = 1; i <= TO; i++) begin
            step();
            chk("t7_read", bus.read, 1);
        end
        step();
        chk("t7_read_drop", bus.read, 0);
        chk("t7_ack", ch_ack, 2'b01);
        chk("t7_err", ch_err, 2'b01);
        chk("t7_rdata", ch_rdata, 32'h0);
        ch_req = 0; bus.waitrequest = 0;
        step();
`endif

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
